// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the multiply/divide unit.
//
// Contents:
//   FUNCT_* : R-type funct codes for the HI/LO instruction group
//   md_state_t : sequencer states (IDLE, CALC, FIX, DONE)
//   md_op_t : latched operation kind (MUL, MULU, DIV, DIVU)
//   funct_is_md / funct_to_op / op_is_signed / op_is_div : decode helpers
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;
  typedef enum logic [1:0] {MUL, MULU, DIV, DIVU} md_op_t;

  function automatic logic funct_is_md(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic md_op_t funct_to_op(input logic [5:0] f);
    md_op_t op;
    case (f)
      FUNCT_MULTU: op = MULU;
      FUNCT_DIV:   op = DIV;
      FUNCT_DIVU:  op = DIVU;
      default:     op = MUL;
    endcase
    return op;
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return (op == MUL) || (op == DIV);
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_iter_core.sv
// md_iter_core: one combinational iteration of the multiply/divide loop.
//
// Ports:
//   is_div   in  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      in  : 2*WIDTH accumulator
//                  multiply: {partial product, remaining multiplier bits}
//                  divide:   {partial remainder, dividend bits / quotient bits}
//   operand  in  : multiplicand (multiply) or divisor (divide) magnitude
//   acc_next out : accumulator after this iteration
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted_rem;
  logic [WIDTH:0] diff;

  // Multiply adds into a WIDTH+1-bit sum so the carry is shifted back into
  // the top of the accumulator. Divide compares the remainder shifted left by
  // one (WIDTH+1 bits, since it can exceed WIDTH bits) against the divisor;
  // the top bit of the difference is the borrow that selects restore.
  always_comb begin
    sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    shifted_rem = acc[2*WIDTH-1:WIDTH-1];
    diff        = shifted_rem - {1'b0, operand};
    acc_next    = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {shifted_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit for the MIPS Execute
// stage, owning the HI/LO registers.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : Execute-stage mult/div instruction (decode-qualified)
//   funct       : R-type funct selecting the operation
//   a, b        : rs / rt operands
//   rd_hilo     : MFHI/MFLO in Execute
//   wr_hi/wr_lo : MTHI/MTLO, data on wdata
//   hi, lo      : HI/LO registers
//   busy        : unit not IDLE
//   stall       : hold Execute while the unit or HI/LO is in use
//   done        : one-cycle pulse when HI/LO hold a new result
//
// Optional build macro MD_EARLY_TERM_EN: multiplies finish as soon as the
// remaining multiplier bits are all zero. Without it every operation takes
// exactly WIDTH CALC cycles.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t            state;
  md_state_t            state_next;
  md_op_t               op;
  md_op_t               new_op;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     operand;
  logic [CW-1:0]        counter;
  logic                 sign_q;
  logic                 sign_a;
  logic                 b_zero;
  logic                 start_ok;
  logic                 last_iter;
  logic                 early_exit;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  md_iter_core #(.WIDTH(WIDTH)) u_iter (
    .is_div   (op_is_div(op)),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  assign start_ok  = start && funct_is_md(funct);
  assign last_iter = (counter == CW'(WIDTH - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign stall     = busy && (start || rd_hilo || wr_hi || wr_lo);

  // Operand magnitudes at issue. Negation wraps, so the most negative value
  // maps to itself, which is its correct unsigned magnitude.
  always_comb begin
    new_op = funct_to_op(funct);
    a_neg  = op_is_signed(new_op) && a[WIDTH-1];
    b_neg  = op_is_signed(new_op) && b[WIDTH-1];
    abs_a  = a_neg ? (~a + WIDTH'(1)) : a;
    abs_b  = b_neg ? (~b + WIDTH'(1)) : b;
  end

`ifdef MD_EARLY_TERM_EN
  logic [WIDTH-1:0] mult_rem;
  logic [CW-1:0]    shamt;

  // mult_rem shadows the multiplier bits not yet consumed. Once they are all
  // zero the remaining iterations would only shift, so FIX applies that
  // shift in one step instead.
  assign early_exit = !op_is_div(op) && ((mult_rem >> 1) == '0);
  assign shamt      = CW'(WIDTH) - counter;
  assign product    = acc >> shamt;
`else
  assign early_exit = 1'b0;
  assign product    = acc;
`endif

  assign quotient  = acc[WIDTH-1:0];
  assign remainder = acc[2*WIDTH-1:WIDTH];

  // Sign correction applied in FIX. A zero divisor forces LO to all ones;
  // the remainder path already yields the original dividend in that case.
  always_comb begin
    res_hi = product[2*WIDTH-1:WIDTH];
    res_lo = product[WIDTH-1:0];
    if (op_is_div(op)) begin
      res_hi = sign_a ? (~remainder + WIDTH'(1)) : remainder;
      res_lo = sign_q ? (~quotient + WIDTH'(1)) : quotient;
      if (b_zero) begin
        res_lo = '1;
      end
    end else if (sign_q) begin
      res_hi = (~product + (2*WIDTH)'(1)) >> WIDTH;
      res_lo = WIDTH'(~product + (2*WIDTH)'(1));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = CALC;
      CALC: if (last_iter || early_exit) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and HI/LO. A start in IDLE wins over a simultaneous MTHI/MTLO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= MUL;
      acc     <= '0;
      operand <= '0;
      counter <= '0;
      sign_q  <= 1'b0;
      sign_a  <= 1'b0;
      b_zero  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MD_EARLY_TERM_EN
      mult_rem <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            op      <= new_op;
            counter <= '0;
            sign_q  <= a_neg ^ b_neg;
            sign_a  <= a_neg;
            b_zero  <= (b == '0);
            if (op_is_div(new_op)) begin
              acc     <= {{WIDTH{1'b0}}, abs_a};
              operand <= abs_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, abs_b};
              operand <= abs_a;
            end
`ifdef MD_EARLY_TERM_EN
            mult_rem <= abs_b;
`endif
          end else if (!start) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        CALC: begin
          acc     <= acc_next;
          counter <= counter + CW'(1);
`ifdef MD_EARLY_TERM_EN
          mult_rem <= mult_rem >> 1;
`endif
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
